timer_counter: RTL

Memory-mapped programmable timer that sits behind the CPU's data-bus bridge as a bus responder. It is the hardware source of the `interrupt` input the CPU bench drives. It counts down from a software-loaded preset and raises `irq` on terminal count. It supports one-shot and auto-reload modes. The bridge decodes the device window and presents word-aligned register accesses.

---
 rtl/timer_counter.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/timer_counter.sv
// timer_counter: memory-mapped down-counting timer with one-shot and
// auto-reload modes, raising irq on terminal count.
//
// Ports:
//   clk    - system clock, all state updates on posedge
//   reset  - synchronous active-high reset
//   addr   - byte address from the bus bridge, only addr[3:2] decoded
//   we     - word write strobe (device already selected by the bridge)
//   wdata  - write data
//   rdata  - combinational read data for addr[3:2]
//   irq    - interrupt request, CTRL.IM & irq_flag
//
// Register map (addr[3:2]):
//   0 CTRL   : bit0 EN, bits2:1 MODE (01 = auto-reload, else one-shot), bit3 IM
//   1 PRESET : read/write reload value
//   2 COUNT  : read-only current count
//   3 reserved, reads 0

module timer_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      addr,
    input  logic             we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             irq
);

    localparam int unsigned CTRL_W = 4;
    localparam int unsigned SEL_W  = 2;

    localparam logic [SEL_W-1:0] SEL_CTRL   = 2'd0;
    localparam logic [SEL_W-1:0] SEL_PRESET = 2'd1;
    localparam logic [SEL_W-1:0] SEL_COUNT  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
    logic [WIDTH-1:0]    preset_q, preset_d;
    logic [WIDTH-1:0]    count_q, count_d;
    logic                flag_q, flag_d;

    logic [SEL_W-1:0]    sel;
    logic                en;
    logic                auto_mode;
    logic                wr_ctrl;
    logic                wr_preset;
    logic                count_gt1;
    logic                unused_addr;

    assign sel         = addr[3:2];
    assign unused_addr = ^{addr[31:4], addr[1:0]};

    assign en        = ctrl_q[0];
    // Only MODE 01 reloads; 10 and 11 fall back to one-shot.
    assign auto_mode = (ctrl_q[2:1] == 2'b01);
    assign wr_ctrl   = we && (sel == SEL_CTRL);
    assign wr_preset = we && (sel == SEL_PRESET);
    assign count_gt1 = (count_q > WIDTH'(1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (en) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = S_CNT;
            end
            S_CNT: begin
                if (!en) begin
                    state_d = S_IDLE;
                end else if (!count_gt1) begin
                    state_d = S_INT;
                end
            end
            S_INT: begin
                if (auto_mode && en) begin
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Register next values; bus writes are applied last so they override
    // the FSM's own updates on the same edge.
    always_comb begin
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        flag_d   = flag_q;

        case (state_q)
            S_LOAD: begin
                count_d = preset_q;
            end
            S_CNT: begin
                if (en) begin
                    if (count_gt1) begin
                        count_d = count_q - WIDTH'(1);
                    end else begin
                        // Terminal count; a count of 0 saturates here too.
                        count_d = '0;
                        flag_d  = 1'b1;
                    end
                end
            end
            S_INT: begin
                if (auto_mode) begin
                    flag_d = 1'b0;
                end else begin
                    ctrl_d[0] = 1'b0;
                end
            end
            default: begin
            end
        endcase

        if (wr_ctrl) begin
            ctrl_d = wdata[CTRL_W-1:0];
            flag_d = 1'b0;
        end
        if (wr_preset) begin
            preset_d = wdata;
            flag_d   = 1'b0;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q   <= '0;
            preset_q <= '0;
            count_q  <= '0;
            flag_q   <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            flag_q   <= flag_d;
        end
    end

    // Outputs: combinational read mux and masked interrupt
    always_comb begin
        rdata = '0;
        case (sel)
            SEL_CTRL:   rdata = WIDTH'(ctrl_q);
            SEL_PRESET: rdata = preset_q;
            SEL_COUNT:  rdata = count_q;
            default:    rdata = '0;
        endcase
        irq = ctrl_q[3] & flag_q;
    end

endmodule
